// File: rtl/fetch_unit_if.sv
// Request/response channel between the fetch unit and the instruction cache.
// The master side issues word reads; the slave side accepts them and returns data.
interface fetch_unit_if;
    logic        icache_re;
    logic [29:0] icache_addr;
    logic        icache_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_dout;

    modport master (
        output icache_re,
        output icache_addr,
        input  icache_ready,
        input  icache_resp_valid,
        input  icache_dout
    );

    modport slave (
        input  icache_re,
        input  icache_addr,
        output icache_ready,
        output icache_resp_valid,
        output icache_dout
    );
endinterface

// File: rtl/fetch_unit.sv
// Stage-1 fetch sequencer: one outstanding I-cache read per PC, a registered output
// with a one-entry skid buffer, PC back-pressure and wrong-path squashing on redirect.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_2000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    input  logic         redirect,
    input  logic         stall_in,
    fetch_unit_if.master icache,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic         inst_valid,
    output logic         pc_stall
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t      state, state_next;
    logic        squash;
    logic [31:0] req_pc;
    entry_t      skid;

    logic fire, consume, out_free, flush;
    logic resp_drop, load_resp, load_skid, skid_to_out, set_squash;

    assign icache.icache_addr = pc[31:2];
    assign consume            = inst_valid & ~stall_in;
    assign out_free           = ~inst_valid | consume;
    assign flush              = redirect & (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        icache.icache_re = 1'b0;
        fire             = 1'b0;
        resp_drop        = 1'b0;
        load_resp        = 1'b0;
        load_skid        = 1'b0;
        skid_to_out      = 1'b0;
        set_squash       = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                icache.icache_re = ~redirect;
                fire             = ~redirect & icache.icache_ready;
                if (fire) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (icache.icache_resp_valid) begin
                    state_next = S_REQ;
                    if (squash | redirect) resp_drop = 1'b1;
                    else if (out_free)     load_resp = 1'b1;
                    else begin
                        load_skid  = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (redirect) begin
                    set_squash = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_next = S_REQ;
                end else if (consume) begin
                    skid_to_out = 1'b1;
                    state_next  = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase
        pc_stall = ~(fire | flush);
    end

    // A redirect seen before the response arrives marks that response as wrong-path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           squash <= 1'b0;
        else if (resp_drop)  squash <= 1'b0;
        else if (set_squash) squash <= 1'b1;
    end

    // Flush outranks any load landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_valid <= 1'b0;
            inst       <= NOP;
            inst_pc    <= PC_RESET;
        end else if (flush) begin
            inst_valid <= 1'b0;
            inst       <= NOP;
        end else if (load_resp) begin
            inst_valid <= 1'b1;
            inst       <= icache.icache_dout;
            inst_pc    <= req_pc;
        end else if (skid_to_out) begin
            inst_valid <= 1'b1;
            inst       <= skid.inst;
            inst_pc    <= skid.pc;
        end else if (consume) begin
            inst_valid <= 1'b0;
            inst       <= NOP;
        end
    end

    // NOTE: req_pc and skid are pure datapath, only read after being written under the
    // FSM's control, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fire)      req_pc <= pc;
        if (load_skid) skid   <= {icache.icache_dout, req_pc};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the fetch pipeline.
module tb_fetch_unit;
    localparam logic [31:0] PC_RESET = 32'h0000_2000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = PC_RESET;
    logic        redirect = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, pc_stall;

    fetch_unit_if bus();

    fetch_unit #(.PC_RESET(PC_RESET), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .redirect(redirect), .stall_in(stall_in),
        .icache(bus), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .pc_stall(pc_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: instructions delivered to stage 2 form a queue (head = output, next = skid).
    bit          m_started, m_inflight, m_wrong;
    logic [31:0] m_inflight_pc, m_last_pc;
    entry_t      m_q[$];

    // Behavioural cache: answers each accepted read after c_lat cycles.
    bit c_pending = 1'b0;
    int c_cnt = 0;
    int c_lat = 1;
    bit spurious_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_inflight = 1'b0;
        m_wrong    = 1'b0;
        m_q.delete();
        m_last_pc  = PC_RESET;
        pc         = PC_RESET;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'(0));
        check({tag, "_inst"}, inst, NOP);
        check({tag, "_inst_pc"}, inst_pc, PC_RESET);
        check({tag, "_icache_re"}, 32'(bus.icache_re), 32'(0));
        check({tag, "_pc_stall"}, 32'(pc_stall), 32'(1));
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit st, input bit rdy,
                         input logic [31:0] data);
        bit         resp, exp_re, exp_fire, exp_stall, consume;
        logic [31:0] exp_inst;
        @(negedge clk);
        redirect = rd;
        stall_in = st;
        bus.icache_ready = rdy;
        resp = c_pending && (c_cnt == 0);
        if (!resp && !c_pending && spurious_en && ($urandom_range(0, 9) == 0)) resp = 1'b1;
        bus.icache_resp_valid = resp;
        bus.icache_dout = resp ? data : $urandom();

        exp_re    = m_started && !m_inflight && (m_q.size() < 2) && !rd;
        exp_fire  = exp_re && rdy;
        exp_stall = !(exp_fire || (rd && m_started));
        exp_inst  = NOP;
        if (m_q.size() > 0) exp_inst = m_q[0].inst;
        #1;
        check("icache_re", 32'(bus.icache_re), 32'(exp_re));
        check("icache_addr", 32'(bus.icache_addr), 32'(pc[31:2]));
        check("pc_stall", 32'(pc_stall), 32'(exp_stall));
        check("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
        check("inst", inst, exp_inst);
        check("inst_pc", inst_pc, m_last_pc);

        @(posedge clk);
        #1;
        consume = (m_q.size() > 0) && !st;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (rd) begin
            m_q.delete();
            if (m_inflight) begin
                if (resp) begin
                    m_inflight = 1'b0;
                    m_wrong    = 1'b0;
                end else begin
                    m_wrong = 1'b1;
                end
            end
        end else begin
            if (consume) void'(m_q.pop_front());
            if (m_inflight && resp) begin
                m_inflight = 1'b0;
                if (!m_wrong) m_q.push_back({data, m_inflight_pc});
                m_wrong = 1'b0;
            end
            if (exp_fire) begin
                m_inflight    = 1'b1;
                m_inflight_pc = pc;
            end
        end
        if (m_q.size() > 0) m_last_pc = m_q[0].pc;

        if (c_pending) begin
            if (c_cnt == 0) c_pending = 1'b0;
            else            c_cnt--;
        end
        if (exp_fire) begin
            c_pending = 1'b1;
            c_cnt     = c_lat - 1;
        end

        if (!exp_stall) pc = rd ? tgt : pc + 32'd4;
    endtask

    initial begin
        bus.icache_ready      = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.icache_dout       = '0;
        model_reset();

        // Power-on reset, checked asynchronously before any clock edge.
        #1 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Free-run with a 1-cycle cache: outputs at cycles 3 and 5.
        c_lat = 1;
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, 32'h0010_0093);
        check("run_c3_valid", 32'(inst_valid), 32'(1));
        check("run_c3_inst", inst, 32'h0010_0093);
        check("run_c3_pc", inst_pc, 32'h0000_2000);
        cycle(0, 0, 0, 1, $urandom());
        check("run_c4_valid", 32'(inst_valid), 32'(0));
        cycle(0, 0, 0, 1, 32'h0020_0113);
        check("run_c5_inst", inst, 32'h0020_0113);
        check("run_c5_pc", inst_pc, 32'h0000_2004);
        cycle(0, 0, 0, 1, $urandom());

        // Reset with a request in flight; its stale response lands after reset.
        async_reset("rst1");

        // Cache back-pressure in REQ.
        cycle(0, 0, 0, 1, 32'hBAD0_BAD0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, $urandom());
            check("bp_addr", 32'(bus.icache_addr), 32'h0000_0800);
        end

        // Downstream stall: second response goes to skid and appears on release.
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, 32'h1111_0001);
        cycle(0, 0, 1, 1, $urandom());
        cycle(0, 0, 1, 1, 32'h2222_0002);
        cycle(0, 0, 1, 1, $urandom());
        cycle(0, 0, 1, 1, $urandom());
        check("stall_hold_inst", inst, 32'h1111_0001);
        cycle(0, 0, 0, 1, $urandom());
        check("skid_inst", inst, 32'h2222_0002);
        check("skid_pc", inst_pc, 32'h0000_2004);

        // Redirect in WAIT; the response two cycles later is discarded.
        c_lat = 3;
        cycle(0, 0, 0, 1, $urandom());
        cycle(1, 32'h0000_4000, 0, 1, $urandom());
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, 32'hDEAD_BEEF);
        check("squash_valid", 32'(inst_valid), 32'(0));
        check("squash_addr", 32'(bus.icache_addr), 32'h0000_1000);
        c_lat = 1;
        cycle(0, 0, 0, 0, $urandom());

        // Redirect in REQ, then in HOLD.
        cycle(1, 32'h0000_6000, 0, 1, $urandom());
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, 32'h3333_0003);
        cycle(0, 0, 1, 1, $urandom());
        cycle(0, 0, 1, 1, 32'h4444_0004);
        cycle(1, 32'h0000_8000, 1, 1, $urandom());
        check("hold_flush_valid", 32'(inst_valid), 32'(0));
        check("hold_flush_inst", inst, NOP);
        cycle(0, 0, 0, 0, $urandom());

        // Reset mid-WAIT with a valid output held; stale response follows.
        cycle(0, 0, 0, 1, $urandom());
        cycle(0, 0, 0, 1, 32'h5555_0005);
        c_lat = 3;
        cycle(0, 0, 1, 1, $urandom());
        cycle(0, 0, 1, 1, $urandom());
        async_reset("rst2");
        cycle(0, 0, 0, 1, 32'hBAD0_BAD0);
        cycle(0, 0, 0, 1, 32'hBAD0_BAD0);

        // Random traffic with spurious responses and variable cache latency.
        spurious_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            c_lat = $urandom_range(1, 4);
            cycle($urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
